// File: rtl/cnt_pkg.sv
// Shared encodings for the universal modulo counter: counting modes and
// the RUN/HALT state of the one-shot controller.
package cnt_pkg;

   // Mode 2'b11 is reserved and behaves exactly like MODE_FREE.
   typedef enum logic [1:0] {
      MODE_FREE     = 2'b00,
      MODE_SAT      = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_FREE_ALT = 2'b11
   } cnt_mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } cnt_state_e;

   // SAT and ONESHOT both clamp at the range ends instead of wrapping.
   function automatic logic mode_clamps(input logic [1:0] mode);
      return (mode == MODE_SAT) || (mode == MODE_ONESHOT);
   endfunction

endpackage

// File: rtl/mod_step_alu.sv
// Combinational step unit for univ_mod_counter: clamps the step to the
// range, then adds or subtracts it in N+1 bits and either wraps modulo
// (mod_max + 1) or clamps at the range end.
module mod_step_alu #(
   parameter int N = 8
) (
   input  logic [N-1:0] q,
   input  logic [N-1:0] step,
   input  logic [N-1:0] mod_max,
   input  logic         up,
   input  logic         clamp,
   output logic [N-1:0] q_next,
   output logic         pass,
   output logic         zero_step
);

   logic [N-1:0] s;
   logic [N:0]   q_x;
   logic [N:0]   s_x;
   logic [N:0]   max_x;
   logic [N:0]   span;
   logic [N:0]   sum;
   logic [N:0]   wrap_up;
   logic [N:0]   diff;
   logic [N:0]   wrap_dn;

   // Extending everything by one bit keeps q + s and q + mod_max + 1 exact,
   // so the pass-the-end decision never sees a truncated result.
   always_comb begin
      s         = (step > mod_max) ? mod_max : step;
      zero_step = (s == '0);
      q_x       = {1'b0, q};
      s_x       = {1'b0, s};
      max_x     = {1'b0, mod_max};
      span      = max_x + (N+1)'(1);
      sum       = q_x + s_x;
      wrap_up   = sum - span;
      diff      = q_x - s_x;
      wrap_dn   = q_x + span - s_x;
      q_next    = q;
      pass      = 1'b0;
      if (up) begin
         if (sum > max_x) begin
            pass   = 1'b1;
            q_next = clamp ? mod_max : wrap_up[N-1:0];
         end else begin
            q_next = sum[N-1:0];
         end
      end else begin
         if (q_x >= s_x) begin
            q_next = diff[N-1:0];
         end else begin
            pass   = 1'b1;
            q_next = clamp ? '0 : wrap_dn[N-1:0];
         end
      end
   end

endmodule

// File: rtl/univ_mod_counter.sv
// Universal modulo counter: up/down counting over 0..mod_max with a
// programmable step, wrapping (FREE), saturating (SAT) or stopping once
// the end is reached (ONESHOT).
// Optional build macro UNIV_MOD_COUNTER_STICKY_EN adds sticky overflow and
// underflow flags (ovf, unf) with their clear input sts_clr.
module univ_mod_counter
   import cnt_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         syn_clr,
   input  logic         load,
   input  logic         en,
   input  logic         up,
   input  logic [1:0]   mode,
   input  logic [N-1:0] step,
   input  logic [N-1:0] mod_max,
   input  logic [N-1:0] d,
   output logic [N-1:0] q,
   output logic         max_tick,
   output logic         min_tick,
   output logic         wrap_tick,
`ifdef UNIV_MOD_COUNTER_STICKY_EN
   input  logic         sts_clr,
   output logic         ovf,
   output logic         unf,
`endif
   output logic         done
);

   cnt_state_e   state;
   logic         clamp_mode;
   logic         oneshot_mode;
   logic         in_range;
   logic         range_fix;
   logic         count_go;
   logic         lands_end;
   logic         alu_pass;
   logic         alu_zero;
   logic [N-1:0] alu_q;
   logic [N-1:0] d_clamp;

   mod_step_alu #(.N(N)) u_alu (
      .q         (q),
      .step      (step),
      .mod_max   (mod_max),
      .up        (up),
      .clamp     (clamp_mode),
      .q_next    (alu_q),
      .pass      (alu_pass),
      .zero_step (alu_zero)
   );

   // Decode which of the mutually exclusive update paths applies this cycle;
   // an out-of-range count (mod_max lowered under it) is repaired before any
   // normal step is taken.
   always_comb begin
      clamp_mode   = mode_clamps(mode);
      oneshot_mode = (mode == MODE_ONESHOT);
      in_range     = (q <= mod_max);
      d_clamp      = (d > mod_max) ? mod_max : d;
      range_fix    = !syn_clr && !load && (state == ST_RUN) && en && !in_range;
      count_go     = !syn_clr && !load && (state == ST_RUN) && en && in_range && !alu_zero;
      lands_end    = up ? (alu_q == mod_max) : (alu_q == '0);
   end

   assign max_tick = (q == mod_max);
   assign min_tick = (q == '0);

   // Count register, RUN/HALT controller and the registered tick/done outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q         <= '0;
         state     <= ST_RUN;
         wrap_tick <= 1'b0;
         done      <= 1'b0;
      end else begin
         wrap_tick <= 1'b0;
         if (syn_clr) begin
            q     <= '0;
            state <= ST_RUN;
            done  <= 1'b0;
         end else if (load) begin
            q     <= d_clamp;
            state <= ST_RUN;
            done  <= 1'b0;
         end else if (state == ST_HALT) begin
            if (!oneshot_mode) begin
               state <= ST_RUN;
               done  <= 1'b0;
            end
         end else if (range_fix) begin
            q <= up ? '0 : mod_max;
         end else if (count_go) begin
            q         <= alu_q;
            wrap_tick <= alu_pass && !clamp_mode;
            if (oneshot_mode && lands_end) begin
               state <= ST_HALT;
               done  <= 1'b1;
            end
         end
      end
   end

`ifdef UNIV_MOD_COUNTER_STICKY_EN
   // Sticky flags record any step that tried to pass an end, whatever the
   // mode; a new event wins over a clear arriving in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (count_go && alu_pass && up) begin
            ovf <= 1'b1;
         end else if (sts_clr) begin
            ovf <= 1'b0;
         end
         if (count_go && alu_pass && !up) begin
            unf <= 1'b1;
         end else if (sts_clr) begin
            unf <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_univ_mod_counter.sv
// Directed self-checking bench for univ_mod_counter at N = 4.
// Define UNIV_MOD_COUNTER_STICKY_EN for both bench and RTL to exercise the
// sticky ovf/unf flags.
module tb_univ_mod_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       syn_clr;
   logic       load;
   logic       en;
   logic       up;
   logic [1:0] mode;
   logic [3:0] step;
   logic [3:0] mod_max;
   logic [3:0] d;
   logic [3:0] q;
   logic       max_tick;
   logic       min_tick;
   logic       wrap_tick;
   logic       done;
`ifdef UNIV_MOD_COUNTER_STICKY_EN
   logic       sts_clr;
   logic       ovf;
   logic       unf;
`endif

   int n_vectors     = 0;
   int n_miscompares = 0;

   univ_mod_counter #(.N(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .syn_clr   (syn_clr),
      .load      (load),
      .en        (en),
      .up        (up),
      .mode      (mode),
      .step      (step),
      .mod_max   (mod_max),
      .d         (d),
      .q         (q),
      .max_tick  (max_tick),
      .min_tick  (min_tick),
      .wrap_tick (wrap_tick),
`ifdef UNIV_MOD_COUNTER_STICKY_EN
      .sts_clr   (sts_clr),
      .ovf       (ovf),
      .unf       (unf),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      syn_clr = 1'b0;
      load    = 1'b0;
      en      = 1'b0;
      up      = 1'b1;
      mode    = 2'b00;
      step    = 4'd1;
      mod_max = 4'd9;
      d       = 4'd0;
`ifdef UNIV_MOD_COUNTER_STICKY_EN
      sts_clr = 1'b0;
`endif
      cycle();
      cycle();
      n_vectors++;
      if ({q, wrap_tick, done, min_tick} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL reset_state: got q=%0d wrap=%b done=%b min=%b, want q=0 wrap=0 done=0 min=1",
                  q, wrap_tick, done, min_tick);
      end
`ifdef UNIV_MOD_COUNTER_STICKY_EN
      n_vectors++;
      if ({ovf, unf} !== 2'b00) begin
         n_miscompares++;
         $display("[TB] FAIL reset_sticky: got ovf=%b unf=%b, want 0 0", ovf, unf);
      end
`endif
      reset = 1'b1;
   endtask

   task automatic test_free_up();
      logic [3:0] exp_q;
      logic       exp_w;
      mode    = 2'b00;
      mod_max = 4'd9;
      step    = 4'd1;
      up      = 1'b1;
      en      = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         exp_q = 4'((i + 1) % 10);
         exp_w = (i == 9);
         n_vectors++;
         if ({q, wrap_tick, max_tick} !== {exp_q, exp_w, (exp_q == 4'd9)}) begin
            n_miscompares++;
            $display("[TB] FAIL free_up c%0d: got q=%0d wrap=%b max=%b, want q=%0d wrap=%b max=%b",
                     i, q, wrap_tick, max_tick, exp_q, exp_w, (exp_q == 4'd9));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_down_wrap_sat();
      load = 1'b1;
      d    = 4'd1;
      cycle();
      load = 1'b0;
      n_vectors++;
      if (q !== 4'd1) begin
         n_miscompares++;
         $display("[TB] FAIL load_one: got q=%0d, want 1", q);
      end
      en   = 1'b1;
      up   = 1'b0;
      step = 4'd3;
      cycle();
      en = 1'b0;
      n_vectors++;
      if ({q, wrap_tick} !== {4'd8, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL free_down_wrap: got q=%0d wrap=%b, want q=8 wrap=1", q, wrap_tick);
      end
      cycle();
      n_vectors++;
      if ({q, wrap_tick} !== {4'd8, 1'b0}) begin
         n_miscompares++;
         $display("[TB] FAIL wrap_one_cycle: got q=%0d wrap=%b, want q=8 wrap=0", q, wrap_tick);
      end
      mode = 2'b01;
      load = 1'b1;
      d    = 4'd1;
      cycle();
      load = 1'b0;
      en   = 1'b1;
      cycle();
      en = 1'b0;
      n_vectors++;
      if ({q, wrap_tick, min_tick} !== {4'd0, 1'b0, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL sat_down: got q=%0d wrap=%b min=%b, want q=0 wrap=0 min=1", q, wrap_tick, min_tick);
      end
      mode = 2'b11;
      load = 1'b1;
      d    = 4'd9;
      cycle();
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b1;
      step = 4'd1;
      cycle();
      en = 1'b0;
      n_vectors++;
      if ({q, wrap_tick} !== {4'd0, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL mode11_free: got q=%0d wrap=%b, want q=0 wrap=1", q, wrap_tick);
      end
   endtask

   task automatic test_oneshot();
      mode    = 2'b10;
      mod_max = 4'd5;
      up      = 1'b1;
      step    = 4'd1;
      syn_clr = 1'b1;
      cycle();
      syn_clr = 1'b0;
      en      = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cycle();
         n_vectors++;
         if ({q, done} !== {4'(i), (i == 5)}) begin
            n_miscompares++;
            $display("[TB] FAIL oneshot_run c%0d: got q=%0d done=%b, want q=%0d done=%b",
                     i, q, done, i, (i == 5));
         end
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_vectors++;
         if ({q, done, wrap_tick} !== {4'd5, 1'b1, 1'b0}) begin
            n_miscompares++;
            $display("[TB] FAIL oneshot_halt c%0d: got q=%0d done=%b wrap=%b, want q=5 done=1 wrap=0",
                     i, q, done, wrap_tick);
         end
      end
      load = 1'b1;
      d    = 4'd2;
      cycle();
      load = 1'b0;
      en   = 1'b0;
      n_vectors++;
      if ({q, done} !== {4'd2, 1'b0}) begin
         n_miscompares++;
         $display("[TB] FAIL oneshot_reload: got q=%0d done=%b, want q=2 done=0", q, done);
      end
   endtask

   task automatic test_priority();
      mode    = 2'b00;
      mod_max = 4'd9;
      up      = 1'b1;
      step    = 4'd1;
      syn_clr = 1'b1;
      load    = 1'b1;
      en      = 1'b1;
      d       = 4'd7;
      cycle();
      n_vectors++;
      if (q !== 4'd0) begin
         n_miscompares++;
         $display("[TB] FAIL clr_wins: got q=%0d, want 0", q);
      end
      syn_clr = 1'b0;
      d       = 4'd12;
      cycle();
      load = 1'b0;
      en   = 1'b0;
      n_vectors++;
      if ({q, max_tick} !== {4'd9, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL load_clamp: got q=%0d max=%b, want q=9 max=1", q, max_tick);
      end
   endtask

   task automatic test_range_fix();
      mode    = 2'b00;
      mod_max = 4'd9;
      load    = 1'b1;
      d       = 4'd8;
      cycle();
      load    = 1'b0;
      mod_max = 4'd5;
      en      = 1'b1;
      up      = 1'b1;
      step    = 4'd1;
      cycle();
      en = 1'b0;
      n_vectors++;
      if ({q, wrap_tick} !== {4'd0, 1'b0}) begin
         n_miscompares++;
         $display("[TB] FAIL range_fix_up: got q=%0d wrap=%b, want q=0 wrap=0", q, wrap_tick);
      end
      mod_max = 4'd9;
      load    = 1'b1;
      cycle();
      load    = 1'b0;
      mod_max = 4'd5;
      en      = 1'b1;
      up      = 1'b0;
      cycle();
      en = 1'b0;
      n_vectors++;
      if ({q, wrap_tick} !== {4'd5, 1'b0}) begin
         n_miscompares++;
         $display("[TB] FAIL range_fix_down: got q=%0d wrap=%b, want q=5 wrap=0", q, wrap_tick);
      end
   endtask

   task automatic test_async_reset();
      mode    = 2'b00;
      mod_max = 4'd3;
      step    = 4'd1;
      up      = 1'b1;
      en      = 1'b1;
      syn_clr = 1'b1;
      cycle();
      syn_clr = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      n_vectors++;
      if ({q, wrap_tick} !== {4'd0, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL pre_reset_wrap: got q=%0d wrap=%b, want q=0 wrap=1", q, wrap_tick);
      end
      #2 reset = 1'b0;
      #1;
      n_vectors++;
      if ({q, wrap_tick, done} !== {4'd0, 1'b0, 1'b0}) begin
         n_miscompares++;
         $display("[TB] FAIL async_reset: got q=%0d wrap=%b done=%b, want 0 0 0", q, wrap_tick, done);
      end
      cycle();
      n_vectors++;
      if (q !== 4'd0) begin
         n_miscompares++;
         $display("[TB] FAIL reset_hold: got q=%0d, want 0", q);
      end
      reset = 1'b1;
      cycle();
      n_vectors++;
      if (q !== 4'd1) begin
         n_miscompares++;
         $display("[TB] FAIL first_edge: got q=%0d, want 1", q);
      end
      mode = 2'b10;
      cycle();
      cycle();
      n_vectors++;
      if ({q, done} !== {4'd3, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL halt_before_reset: got q=%0d done=%b, want q=3 done=1", q, done);
      end
      #2 reset = 1'b0;
      #1;
      n_vectors++;
      if ({q, done} !== {4'd0, 1'b0}) begin
         n_miscompares++;
         $display("[TB] FAIL reset_in_halt: got q=%0d done=%b, want q=0 done=0", q, done);
      end
      en = 1'b0;
      cycle();
      reset = 1'b1;
      mode  = 2'b00;
   endtask

`ifdef UNIV_MOD_COUNTER_STICKY_EN
   task automatic test_sticky();
      mode    = 2'b01;
      mod_max = 4'd9;
      load    = 1'b1;
      d       = 4'd8;
      cycle();
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b1;
      step = 4'd3;
      cycle();
      en = 1'b0;
      n_vectors++;
      if ({q, ovf, unf} !== {4'd9, 1'b1, 1'b0}) begin
         n_miscompares++;
         $display("[TB] FAIL sat_ovf: got q=%0d ovf=%b unf=%b, want q=9 ovf=1 unf=0", q, ovf, unf);
      end
      cycle();
      cycle();
      n_vectors++;
      if (ovf !== 1'b1) begin
         n_miscompares++;
         $display("[TB] FAIL ovf_sticky: got ovf=%b, want 1", ovf);
      end
      sts_clr = 1'b1;
      cycle();
      sts_clr = 1'b0;
      n_vectors++;
      if (ovf !== 1'b0) begin
         n_miscompares++;
         $display("[TB] FAIL ovf_clear: got ovf=%b, want 0", ovf);
      end
      sts_clr = 1'b1;
      en      = 1'b1;
      cycle();
      sts_clr = 1'b0;
      en      = 1'b0;
      n_vectors++;
      if (ovf !== 1'b1) begin
         n_miscompares++;
         $display("[TB] FAIL set_beats_clear: got ovf=%b, want 1", ovf);
      end
      load = 1'b1;
      d    = 4'd1;
      cycle();
      load = 1'b0;
      en   = 1'b1;
      up   = 1'b0;
      cycle();
      en = 1'b0;
      n_vectors++;
      if ({q, unf} !== {4'd0, 1'b1}) begin
         n_miscompares++;
         $display("[TB] FAIL sat_unf: got q=%0d unf=%b, want q=0 unf=1", q, unf);
      end
   endtask
`endif

   // Scenario sequence; each task leaves the counter idle for the next one.
   initial begin
      test_reset();
      test_free_up();
      test_down_wrap_sat();
      test_oneshot();
      test_priority();
      test_range_fix();
      test_async_reset();
`ifdef UNIV_MOD_COUNTER_STICKY_EN
      test_sticky();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule

// File: doc/univ_mod_counter.md
UNIV_MOD_COUNTER -- requirements
Module: univ_mod_counter

Interface
REQ-001 SHALL have parameter N, default 8, counter and data width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port syn_clr  input  1  synchronous clear.
REQ-005 SHALL have port load  input  1  synchronous load of d.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port mode  input  2  00 FREE (wrap), 01 SAT (saturate), 10 ONESHOT, 11 is treated as FREE.
REQ-009 SHALL have port step  input  N  count increment; 0 means hold.
REQ-010 SHALL have port mod_max  input  N  terminal value; the count range is 0..mod_max.
REQ-011 SHALL have port d  input  N  load value.
REQ-012 SHALL have port q  output  N  current count, driven directly from the count register.
REQ-013 SHALL have port max_tick  output  1  combinational, equal to (q == mod_max).
REQ-014 SHALL have port min_tick  output  1  combinational, equal to (q == 0).
REQ-015 SHALL have port wrap_tick  output  1  registered one-cycle pulse, set in the cycle after a wrap.
REQ-016 SHALL have port done  output  1  registered; high while the FSM is in HALT.

Function
REQ-017 SHALL apply input priority syn_clr > load > en; with none of the three active, q holds.
REQ-018 SHALL, on syn_clr, set q = 0 and FSM = RUN.
REQ-019 SHALL, on load, set q = min(d, mod_max) and FSM = RUN.
REQ-020 SHALL use effective step s = min(step, mod_max); if s = 0, q holds and no tick is produced.
REQ-021 SHALL compute up/down sums in N+1 bits, so that no intermediate result overflows.
REQ-022 SHALL, counting up with q + s <= mod_max, set q = q + s.
REQ-023 SHALL, counting up past the end, set q = q + s - (mod_max + 1) in FREE and pulse wrap_tick; set q = mod_max in SAT or ONESHOT.
REQ-024 SHALL, counting down with q >= s, set q = q - s.
REQ-025 SHALL, counting down past zero, set q = q - s + mod_max + 1 in FREE and pulse wrap_tick; set q = 0 in SAT or ONESHOT.
REQ-026 SHALL, if q > mod_max when en arrives (mod_max lowered at runtime), force q = 0 when counting up and q = mod_max when counting down, with no wrap_tick.
REQ-027 SHALL implement a two-state FSM: RUN and HALT.
REQ-028 SHALL move RUN -> HALT when mode = ONESHOT and an enabled count lands on mod_max (up) or on 0 (down).
REQ-029 SHALL, in HALT, ignore en, hold q, and keep done = 1.
REQ-030 SHALL leave HALT for RUN on syn_clr, on load, or when mode is not ONESHOT; done falls in the same cycle the FSM re-enters RUN.
REQ-031 SHALL never assert wrap_tick in SAT or ONESHOT; SAT stays in RUN permanently.

Reset
REQ-032 SHALL, while reset = 0, force q = 0, FSM = RUN, wrap_tick = 0, done = 0, and all sticky flags = 0, independent of clk.
REQ-033 SHALL resume counting on the first rising clk edge after reset deasserts.
REQ-034 SHALL, on reset asserted mid-count or in HALT, clear all state immediately; no pending wrap_tick survives.

Configuration
REQ-035 SHALL, with macro UNIV_MOD_COUNTER_STICKY_EN defined, add ports ovf (output, 1), unf (output, 1), and sts_clr (input, 1).
REQ-036 SHALL, with the macro defined, set ovf on any up-count that would pass mod_max and set unf on any down-count that would pass 0, in every mode.
REQ-037 SHALL, with the macro defined, hold ovf and unf until sts_clr or reset; a simultaneous set and sts_clr results in set.
REQ-038 SHALL, without the macro, omit ovf, unf, sts_clr and their logic entirely; all other behaviour is identical.

Structure
REQ-039 SHALL import the mode encodings (MODE_FREE, MODE_SAT, MODE_ONESHOT) and the FSM state encodings from shared package cnt_pkg.
REQ-040 SHALL place the N+1-bit modular add/subtract with wrap/saturate decision in sub-module mod_step_alu (purely combinational); the register, FSM and ticks remain in univ_mod_counter.

Verification
REQ-041 SHALL cover: N=4, mod_max=9, FREE, step=1, up, en=1 for 12 cycles -> q 0..9,0,1; wrap_tick high for one cycle after 9->0.
REQ-042 SHALL cover: N=4, mod_max=9, FREE, step=3, down, from q=1 -> q=8, wrap_tick pulses; SAT with the same stimulus -> q=0, no wrap_tick.
REQ-043 SHALL cover: ONESHOT, mod_max=5, up from 0 -> q reaches 5, done=1, further en leaves q=5; load with d=2 -> q=2, done=0.
REQ-044 SHALL cover: syn_clr, load and en all high with d=7 -> q=0; load with d=12 and mod_max=9 -> q=9.
REQ-045 SHALL cover: q=8, mod_max changed to 5, en up -> q=0, no wrap_tick; reset pulled low mid-count -> q=0 asynchronously, done=0.
REQ-046 SHALL cover, with UNIV_MOD_COUNTER_STICKY_EN defined: SAT overflow -> ovf=1 persists; sts_clr -> ovf=0; without the macro, the ports are absent and the bench compiles.
